// File: rtl/tawas_fetch_pkg.sv
// -----------------------------------------------------------------------------
// tawas_fetch_pkg
// Shared constants for the Tawas instruction fetch path: ROM address width,
// instruction width, the default reset PC and the prefetch FIFO entry width.
// No ports (package).
// -----------------------------------------------------------------------------
package tawas_fetch_pkg;

  localparam int IROM_ADDR_W = 24;
  localparam int INSTR_W     = 32;

  localparam logic [IROM_ADDR_W-1:0] RESET_PC_DEFAULT = '0;

  // A FIFO entry carries {pc, instruction word}.
  function automatic int fifo_entry_w(input int addr_w);
    return addr_w + INSTR_W;
  endfunction

endpackage : tawas_fetch_pkg

// File: rtl/ifetch_fifo.sv
// -----------------------------------------------------------------------------
// ifetch_fifo
// Synchronous prefetch FIFO, DEPTH x WIDTH. The head entry is shown
// combinationally on o_rdata. Flush has priority over push and pop.
// Ports:
//   CLK, RST   clock, asynchronous active-high reset
//   i_push     write i_wdata at the tail
//   i_pop      drop the head (ignored when empty)
//   i_flush    empty the FIFO
//   i_wdata    entry to write
//   o_rdata    head entry
//   o_full     count == DEPTH
//   o_empty    count == 0
//   o_count    number of stored entries
// -----------------------------------------------------------------------------
module ifetch_fifo
  import tawas_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = fifo_entry_w(IROM_ADDR_W),
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_do_push = i_push & ~i_flush;
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; only entries behind valid pointers are read.
  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // The upstream credit rule must make this impossible.
  always @(posedge CLK) begin
    if (!RST) begin
      assert (!(w_do_push && o_full))
        else $error("ifetch_fifo: push into full fifo");
    end
  end

endmodule : ifetch_fifo

// File: rtl/irom_fetch.sv
// -----------------------------------------------------------------------------
// irom_fetch
// Instruction fetch sequencer in front of the instruction ROM. Issues
// sequential word reads, captures the ROM data one cycle later into a small
// prefetch FIFO tagged with its PC, and presents the FIFO head to decode.
// Redirects flush the FIFO, discard the in-flight read and restart at
// REDIRECT_PC.
//
// Handshake: INSTR_VALID/INSTR_READY follow strict valid/ready semantics.
// A transfer happens on a clock edge where both are high; while INSTR_VALID=1
// and INSTR_READY=0, INSTR and INSTR_PC hold. INSTR_VALID never depends on
// INSTR_READY. A REDIRECT cycle overrides any transfer in that cycle.
//
// Ports:
//   CLK, RST       clock, asynchronous active-high reset
//   IROM_ADDR      ROM word address (meaningful when IROM_CS=1)
//   IROM_CS        ROM read strobe
//   IROM_DOUT      ROM data, valid the cycle after IROM_CS
//   REDIRECT       one-cycle flush-and-restart pulse
//   REDIRECT_PC    restart PC, sampled with REDIRECT
//   INSTR_VALID    FIFO head valid
//   INSTR          head instruction word
//   INSTR_PC       head word address
//   INSTR_READY    decode accepts the head
// -----------------------------------------------------------------------------
module irom_fetch
  import tawas_fetch_pkg::*;
#(
  parameter int                ADDR_W     = IROM_ADDR_W,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic               CLK,
  input  logic               RST,
  output logic [ADDR_W-1:0]  IROM_ADDR,
  output logic               IROM_CS,
  input  logic [INSTR_W-1:0] IROM_DOUT,
  input  logic               REDIRECT,
  input  logic [ADDR_W-1:0]  REDIRECT_PC,
  output logic               INSTR_VALID,
  output logic [INSTR_W-1:0] INSTR,
  output logic [ADDR_W-1:0]  INSTR_PC,
  input  logic               INSTR_READY
);

  localparam int ENTRY_W = ADDR_W + INSTR_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_req_pc;
  logic               r_rsp_pending;
  logic [INSTR_W-1:0] r_last_instr;
  logic [ADDR_W-1:0]  r_last_pc;

  logic               w_credit_ok;
  logic               w_issue;
  logic [ADDR_W-1:0]  w_issue_addr;
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_head;
  logic               w_full;
  logic               w_empty;
  logic [CNT_W-1:0]   w_count;

  // Credit: stored entries plus the read in flight must leave room, so every
  // returning word has a slot. A same-cycle pop is deliberately not counted.
  assign w_credit_ok = ({1'b0, w_count} + (CNT_W+1)'(r_rsp_pending))
                       < (CNT_W+1)'(FIFO_DEPTH);
  // A redirect empties the FIFO, so it may always issue.
  assign w_issue      = REDIRECT | w_credit_ok;
  assign w_issue_addr = REDIRECT ? REDIRECT_PC : r_pc;

  // CS is gated by RST so the strobe drops the moment reset asserts.
  assign IROM_CS   = w_issue & ~RST;
  assign IROM_ADDR = w_issue_addr;

  // The response arriving in a redirect cycle belongs to the old path.
  assign w_push = r_rsp_pending & ~REDIRECT;
  assign w_pop  = INSTR_VALID & INSTR_READY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc          <= RESET_PC;
      r_req_pc      <= '0;
      r_rsp_pending <= 1'b0;
    end else begin
      r_rsp_pending <= w_issue;
      if (w_issue) begin
        r_pc     <= w_issue_addr + ADDR_W'(1);
        r_req_pc <= w_issue_addr;
      end
    end
  end

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (REDIRECT),
    .i_wdata ({r_req_pc, IROM_DOUT}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Shadow of the most recently presented head, so the outputs hold their
  // last values once the FIFO drains instead of showing stale storage.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_last_instr <= '0;
      r_last_pc    <= '0;
    end else if (!w_empty) begin
      r_last_instr <= w_head[INSTR_W-1:0];
      r_last_pc    <= w_head[ENTRY_W-1:INSTR_W];
    end
  end

  assign INSTR_VALID = ~w_empty;
  assign INSTR       = w_empty ? r_last_instr : w_head[INSTR_W-1:0];
  assign INSTR_PC    = w_empty ? r_last_pc    : w_head[ENTRY_W-1:INSTR_W];

  // w_full is only consumed by the FIFO's own occupancy check.
  logic w_unused;
  assign w_unused = w_full;

endmodule : irom_fetch

// File: tb/tb_irom_fetch.sv
// -----------------------------------------------------------------------------
// tb_irom_fetch
// Directed bench for irom_fetch. The ROM is modelled as a registered lookup
// whose word is a fixed function of the address, so every delivered word can
// be predicted from its PC. Inputs change at the falling edge; outputs are
// checked 1 ns later.
// -----------------------------------------------------------------------------
module tb_irom_fetch;

  localparam int AW = 24;

  // ---------------- clock / reset ----------------
  logic          CLK = 1'b0;
  logic          RST;
  logic [AW-1:0] IROM_ADDR;
  logic          IROM_CS;
  logic [31:0]   IROM_DOUT;
  logic          REDIRECT;
  logic [AW-1:0] REDIRECT_PC;
  logic          INSTR_VALID;
  logic [31:0]   INSTR;
  logic [AW-1:0] INSTR_PC;
  logic          INSTR_READY;

  always #5 CLK = ~CLK;

  irom_fetch dut (
    .CLK         (CLK),
    .RST         (RST),
    .IROM_ADDR   (IROM_ADDR),
    .IROM_CS     (IROM_CS),
    .IROM_DOUT   (IROM_DOUT),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .INSTR_VALID (INSTR_VALID),
    .INSTR       (INSTR),
    .INSTR_PC    (INSTR_PC),
    .INSTR_READY (INSTR_READY)
  );

  // ---------------- ROM model ----------------
  function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
    return {~a[7:0], a} ^ 32'h5A00_0000;
  endfunction

  logic [31:0] rom_q = '0;
  always @(posedge CLK) if (IROM_CS) rom_q <= rom_word(IROM_ADDR);
  assign IROM_DOUT = rom_q;

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic reset_release(input logic rdy);
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    INSTR_READY = rdy;
    settle();
  endtask

  task automatic expect_head(input string tag, input logic [AW-1:0] pc);
    check({tag, ".valid"}, 64'(INSTR_VALID), 64'd1);
    check({tag, ".pc"}, 64'(INSTR_PC), 64'(pc));
    check({tag, ".instr"}, 64'(INSTR), 64'(rom_word(pc)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST = 1'b1;
    REDIRECT = 1'b0;
    REDIRECT_PC = '0;
    INSTR_READY = 1'b1;
    #12;
    check("rst.cs", 64'(IROM_CS), 64'd0);
    check("rst.valid", 64'(INSTR_VALID), 64'd0);
    check("rst.instr", 64'(INSTR), 64'd0);
    check("rst.pc", 64'(INSTR_PC), 64'd0);

    // ---- streaming with READY held high ----
    reset_release(1'b1);                       // cycle 0
    check("s.c0.cs", 64'(IROM_CS), 64'd1);
    check("s.c0.addr", 64'(IROM_ADDR), 64'd0);
    check("s.c0.valid", 64'(INSTR_VALID), 64'd0);
    cyc(); settle();                           // cycle 1
    check("s.c1.addr", 64'(IROM_ADDR), 64'd1);
    check("s.c1.valid", 64'(INSTR_VALID), 64'd0);
    for (int i = 0; i < 6; i++) begin          // cycles 2..7
      cyc(); settle();
      expect_head($sformatf("s.pc%0d", i), AW'(i));
      check($sformatf("s.cs%0d", i), 64'(IROM_CS), 64'd1);
    end

    // ---- back-pressure from the start ----
    reset_release(1'b0);                       // cycle 0
    for (int i = 0; i < 4; i++) begin          // cycles 0..3
      check($sformatf("bp.cs%0d", i), 64'(IROM_CS), 64'd1);
      check($sformatf("bp.addr%0d", i), 64'(IROM_ADDR), 64'(i));
      cyc(); settle();
    end
    for (int i = 4; i < 7; i++) begin          // cycles 4..6
      check($sformatf("bp.idle%0d", i), 64'(IROM_CS), 64'd0);
      expect_head($sformatf("bp.hold%0d", i), AW'(0));
      cyc(); settle();
    end
    INSTR_READY = 1'b1; settle();              // cycle 7: one pop
    check("bp.c7.cs", 64'(IROM_CS), 64'd0);
    expect_head("bp.c7", AW'(0));
    cyc(); INSTR_READY = 1'b0; settle();       // cycle 8
    check("bp.c8.cs", 64'(IROM_CS), 64'd1);
    check("bp.c8.addr", 64'(IROM_ADDR), 64'd4);
    expect_head("bp.c8", AW'(1));
    cyc(); settle();                           // cycle 9
    check("bp.c9.cs", 64'(IROM_CS), 64'd0);
    expect_head("bp.c9", AW'(1));
    cyc(); settle();                           // cycle 10: FIFO full

    // ---- asynchronous reset mid-stream with a full FIFO ----
    #2 RST = 1'b1;
    #1;
    check("ar.valid", 64'(INSTR_VALID), 64'd0);
    check("ar.cs", 64'(IROM_CS), 64'd0);
    cyc();
    RST = 1'b0; INSTR_READY = 1'b1; settle(); // cycle 0
    check("ar.c0.cs", 64'(IROM_CS), 64'd1);
    check("ar.c0.addr", 64'(IROM_ADDR), 64'd0);
    cyc(); cyc(); settle();                    // cycle 2
    expect_head("ar.c2", AW'(0));

    // ---- redirect with 3 entries stored and a read in flight ----
    reset_release(1'b0);                       // cycle 0
    repeat (4) cyc();                          // cycle 4 = R
    REDIRECT = 1'b1; REDIRECT_PC = 24'h000100; settle();
    check("rd.R.cs", 64'(IROM_CS), 64'd1);
    check("rd.R.addr", 64'(IROM_ADDR), 64'h100);
    expect_head("rd.R", AW'(0));
    cyc(); REDIRECT = 1'b0; settle();          // R+1
    check("rd.R1.valid", 64'(INSTR_VALID), 64'd0);
    check("rd.R1.addr", 64'(IROM_ADDR), 64'h101);
    cyc(); INSTR_READY = 1'b1; settle();       // R+2
    expect_head("rd.R2", 24'h000100);
    cyc(); settle();
    expect_head("rd.R3", 24'h000101);
    cyc(); settle();
    expect_head("rd.R4", 24'h000102);

    // ---- back-to-back redirects ----
    cyc(); REDIRECT = 1'b1; REDIRECT_PC = 24'h000200; settle();
    check("bb.a.addr", 64'(IROM_ADDR), 64'h200);
    cyc(); REDIRECT_PC = 24'h000300; settle();
    check("bb.b.addr", 64'(IROM_ADDR), 64'h300);
    check("bb.b.valid", 64'(INSTR_VALID), 64'd0);
    cyc(); REDIRECT = 1'b0; settle();
    check("bb.c.valid", 64'(INSTR_VALID), 64'd0);
    cyc(); settle();
    expect_head("bb.d", 24'h000300);
    cyc(); settle();
    expect_head("bb.e", 24'h000301);

    // ---- PC wrap ----
    cyc(); REDIRECT = 1'b1; REDIRECT_PC = 24'hFFFFFE; settle();
    cyc(); REDIRECT = 1'b0; settle();
    check("wr.R1.addr", 64'(IROM_ADDR), 64'hFFFFFF);
    cyc(); settle();
    expect_head("wr.0", 24'hFFFFFE);
    check("wr.addr0", 64'(IROM_ADDR), 64'h000000);
    cyc(); settle();
    expect_head("wr.1", 24'hFFFFFF);
    cyc(); settle();
    expect_head("wr.2", 24'h000000);
    cyc(); settle();
    expect_head("wr.3", 24'h000001);

    // ---- final report ----
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_irom_fetch

// File: doc/irom_fetch.md
Name: irom_fetch

Overview:
- Instruction fetch sequencer that sits directly upstream of the instruction ROM. It drives the ROM's word address and chip select, and captures the ROM's 32-bit read data one cycle later.
- Captured words go into a small prefetch FIFO, each tagged with its PC, and are presented to the Tawas core decode stage over a valid/ready handshake.
- Handles sequential prefetch, back-pressure from decode, and PC redirects (branches/jumps), including discarding the in-flight ROM read.

Parameters:
- ADDR_W, 24, width of PC and ROM word address.
- FIFO_DEPTH, 4, prefetch entries; power of 2, minimum 2.
- RESET_PC, 24'h000000, first word fetched after reset.

Ports:
- CLK  in  1  core clock.
- RST  in  1  asynchronous, active-high reset.
- IROM_ADDR  out  ADDR_W  ROM word address; valid only when IROM_CS=1.
- IROM_CS  out  1  ROM read strobe; ROM registers its data on this edge.
- IROM_DOUT  in  32  ROM read data; valid in the cycle after IROM_CS=1.
- REDIRECT  in  1  single-cycle pulse: flush and restart at REDIRECT_PC.
- REDIRECT_PC  in  ADDR_W  new fetch PC; sampled when REDIRECT=1.
- INSTR_VALID  out  1  FIFO head is valid.
- INSTR  out  32  instruction word at the FIFO head.
- INSTR_PC  out  ADDR_W  word address of INSTR.
- INSTR_READY  in  1  decode accepts the head this cycle.

Behaviour:
- Addressing and PC
  - Addresses are word indices. The PC increments by 1 per issued read and wraps from 2^ADDR_W-1 to 0 with no flag.
- Reset
  - While RST=1: pc=RESET_PC, IROM_CS=0, rsp_pending=0, FIFO empty.
  - INSTR_VALID=0, INSTR=0, INSTR_PC=0.
  - Reset deasserting mid-stream simply starts again from RESET_PC.
- Issue rule (evaluated every cycle)
  - Issue when (fifo_count + rsp_pending) < FIFO_DEPTH, using current-cycle values; a same-cycle pop does not count.
  - On issue: IROM_CS=1, IROM_ADDR=pc, pc<=pc+1, rsp_pending<=1.
  - Otherwise IROM_CS=0 and rsp_pending<=0.
  - This rule guarantees that a returning response always has a free FIFO slot, so no data is ever dropped.
- Response capture
  - When rsp_pending=1 and no REDIRECT this cycle, push {pc_of_request, IROM_DOUT} into the FIFO at the clock edge.
  - pc_of_request is a registered copy of the issued address.
- Output latency
  - CS at cycle N → data on IROM_DOUT in N+1 → INSTR_VALID=1 in N+2 if the FIFO was empty.
  - With INSTR_READY held high, the block sustains one instruction per cycle.
- Handshake
  - Pop occurs when INSTR_VALID & INSTR_READY.
  - INSTR and INSTR_PC stay stable while INSTR_VALID=1 and INSTR_READY=0.
  - Push and pop in the same cycle are both performed; count is unchanged.
- Redirect (cycle R)
  - The FIFO is emptied at the edge ending R; INSTR_VALID=0 in R+1. A pop in R is ignored and its data is lost by design, since the redirect supersedes it.
  - Any response arriving in R (from an issue at R-1) is discarded.
  - In the same cycle R: IROM_CS=1, IROM_ADDR=REDIRECT_PC, pc<=REDIRECT_PC+1, rsp_pending<=1. The credit check is bypassed because the FIFO is being emptied.
  - First instruction from the new path: INSTR_VALID=1 in R+2 with INSTR_PC=REDIRECT_PC.
  - Back-to-back redirects: the latest one wins, and each discards the prior in-flight read.
- FIFO boundaries
  - Full: issue is blocked by the credit rule; a push into a full FIFO cannot occur. Assert this in simulation.
  - Empty: INSTR_VALID=0, and INSTR/INSTR_PC hold their last values.
  - Read/write pointers wrap modulo FIFO_DEPTH. The count is $clog2(FIFO_DEPTH)+1 bits wide.
- State machine
  - There is no explicit FSM. State is pc, rsp_pending, a registered request-PC, and the FIFO pointers and count.

Decomposition:
- Shared package (tawas_fetch_pkg)
  - IROM_ADDR_W=24, INSTR_W=32, RESET_PC default.
  - FIFO entry width = ADDR_W+INSTR_W.
- Natural sub-module: ifetch_fifo
  - Synchronous FIFO of FIFO_DEPTH × (ADDR_W+32).
  - Ports: push, pop, flush, full, empty, count.
  - Asynchronous RST; flush has priority over push.

Test Plan:
- Reset, then INSTR_READY=1 held: IROM_CS high from the first cycle after RST falls, addresses 0,1,2,…; INSTR_VALID rises 2 cycles after the first CS; INSTR_PC sequence 0,1,2,3,… at one per cycle; INSTR equals the ROM contents.
- INSTR_READY=0 from the start: exactly 4 CS pulses (addresses 0-3), then CS stays low. Raise READY for 1 cycle → one pop, one new CS at address 4; INSTR holds the address-0 word until popped.
- REDIRECT at cycle R with REDIRECT_PC=24'h000100 while the FIFO holds 3 entries and a read is in flight: IROM_ADDR=0x100 with CS in R; INSTR_VALID=0 in R+1; INSTR_PC=0x100 in R+2; the stale in-flight word never appears.
- REDIRECT in two consecutive cycles to 0x200 then 0x300: the first output is INSTR_PC=0x300; 0x200 never appears.
- Wrap: REDIRECT_PC=24'hFFFFFE with READY=1: INSTR_PC sequence FFFFFE, FFFFFF, 000000, 000001.
- Assert RST mid-stream with a full FIFO: INSTR_VALID=0 and IROM_CS=0 immediately (asynchronous); after release, fetch restarts at RESET_PC.
